// File: rtl/or_and_selector_if.sv
// Operand, enable and result signals of the bitwise AND/OR selector.
// The master side drives the operands and enable; the slave side is the selector.
interface or_and_selector_if;
   logic       ena;      // 1 = load the new result, 0 = hold
   logic [7:0] ui_in;    // operand A, bit 7 also selects the operation
   logic [7:0] uio_in;   // operand B
   logic [7:0] uo_out;   // registered result
   logic [7:0] uio_out;  // unused bidirectional output data
   logic [7:0] uio_oe;   // bidirectional output enables

   modport master (
      output ena,
      output ui_in,
      output uio_in,
      input  uo_out,
      input  uio_out,
      input  uio_oe
   );

   modport slave (
      input  ena,
      input  ui_in,
      input  uio_in,
      output uo_out,
      output uio_out,
      output uio_oe
   );
endinterface

// File: rtl/or_and_selector.sv
// Bitwise combiner of two 8-bit operands. ui_in[7] selects OR (1) or AND (0)
// and takes part in the operation itself. The result is registered with a
// hold-enable and a synchronous active-low clear. The uio bank is input-only.
module or_and_selector (
   input  logic              clk,
   input  logic              rst_n,
   or_and_selector_if.slave  bus
);

   logic [7:0] res;
   logic [7:0] r_d;
   logic [7:0] r_q;

   // Combine the operands according to the op select and choose load or hold.
   always_comb begin
      res = bus.ui_in[7] ? (bus.ui_in | bus.uio_in) : (bus.ui_in & bus.uio_in);
      r_d = r_q;
      if (bus.ena) begin
         r_d = res;
      end
   end

   // Result register; the clear wins over the enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= 8'h00;
      end else begin
         r_q <= r_d;
      end
   end

   // Registered result out; the bidirectional bank stays an input at all times.
   always_comb begin
      bus.uo_out  = r_q;
      bus.uio_out = 8'h00;
      bus.uio_oe  = 8'h00;
   end

endmodule

// File: tb/tb_or_and_selector.sv
// Directed bench for or_and_selector: inputs change on the falling edge,
// outputs are checked 1 ns after the following rising edge.
module tb_or_and_selector;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   or_and_selector_if bus_if ();

   or_and_selector dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of inputs away from the edge, then let one rising edge pass.
   task automatic apply(input logic rst, input logic en, input logic [7:0] a,
                        input logic [7:0] b);
      @(negedge clk);
      rst_n         = rst;
      bus_if.ena    = en;
      bus_if.ui_in  = a;
      bus_if.uio_in = b;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus_if.ena    = 1'b1;
      bus_if.ui_in  = 8'h00;
      bus_if.uio_in = 8'h00;

      // Reset with arbitrary operands.
      apply(1'b0, 1'b1, 8'hA5, 8'h5A);
      check("reset_uo_out", bus_if.uo_out, 8'h00);
      check("reset_uio_out", bus_if.uio_out, 8'h00);
      check("reset_uio_oe", bus_if.uio_oe, 8'h00);

      // AND mode.
      apply(1'b1, 1'b1, 8'b0001_0100, 8'b0001_1110);
      check("and_basic", bus_if.uo_out, 8'b0001_0100);
      check("uio_oe_run", bus_if.uio_oe, 8'h00);

      // OR mode; bit 7 of A forces bit 7 of the result.
      apply(1'b1, 1'b1, 8'b1001_0100, 8'b0001_1110);
      check("or_basic", bus_if.uo_out, 8'b1001_1110);

      apply(1'b1, 1'b1, 8'h00, 8'h00);
      check("zeros", bus_if.uo_out, 8'h00);

      // AND mode cannot set bit 7 even when B[7] is set.
      apply(1'b1, 1'b1, 8'h7F, 8'hFF);
      check("and_bit7_clear", bus_if.uo_out, 8'h7F);

      apply(1'b1, 1'b1, 8'h0F, 8'hF0);
      check("and_disjoint", bus_if.uo_out, 8'h00);

      apply(1'b1, 1'b1, 8'h80, 8'h0F);
      check("or_disjoint", bus_if.uo_out, 8'h8F);

      // Op select changes between edges; only the value at the edge counts.
      @(negedge clk);
      bus_if.ena    = 1'b1;
      bus_if.ui_in  = 8'h94;
      bus_if.uio_in = 8'h1E;
      #2;
      check("no_change_before_edge", bus_if.uo_out, 8'h8F);
      bus_if.ui_in = 8'h14;
      @(posedge clk);
      #1;
      check("select_at_edge", bus_if.uo_out, 8'h14);

      // Load all ones, then hold with ena low.
      apply(1'b1, 1'b1, 8'hFF, 8'b1010_1010);
      check("or_all_ones", bus_if.uo_out, 8'hFF);
      apply(1'b1, 1'b0, 8'h00, 8'b1010_1010);
      check("hold_1", bus_if.uo_out, 8'hFF);
      apply(1'b1, 1'b0, 8'h00, 8'h00);
      check("hold_2", bus_if.uo_out, 8'hFF);

      // Reset overrides a low enable.
      apply(1'b0, 1'b0, 8'h00, 8'h00);
      check("reset_ena_low", bus_if.uo_out, 8'h00);
      check("reset_uio_out_2", bus_if.uio_out, 8'h00);

      // After release, nothing loads until ena is high.
      apply(1'b1, 1'b0, 8'hFF, 8'h00);
      check("post_reset_hold", bus_if.uo_out, 8'h00);
      apply(1'b1, 1'b1, 8'hFF, 8'h00);
      check("post_reset_load", bus_if.uo_out, 8'hFF);

      // Reset asserted mid-operation while enabled.
      apply(1'b0, 1'b1, 8'hFF, 8'hFF);
      check("reset_mid_op", bus_if.uo_out, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
